mips_prog_loader: RTL and testbench
===================================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10; meaning: instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF; meaning: end-of-program instruction word (HLT opcode 6'b111111).
REQ-003 SHALL use one clock and a synchronous, active-high reset; port clk1  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to (re)start program loading.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  program byte, most-significant byte of each word first.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port core_start  output  1  one-cycle pulse: core clears HALTED and sets PC to 0.
REQ-013 SHALL have port core_run  output  1  high while the core is released to execute.
REQ-014 SHALL have port word_count  output  ADDR_W+1  number of words written in the current load.
REQ-015 SHALL have port err_overflow  output  1  memory filled without HALT_WORD.

Function
REQ-016 SHALL implement states IDLE, LOAD, START, RUN, ERROR.
REQ-017 SHALL drive in_ready = 1 only in LOAD; a byte transfers on in_valid && in_ready.
REQ-018 SHALL, on load_start in any state, enter LOAD next cycle with byte index 0, word address 0, word_count 0, core_run 0, err_overflow 0, and discard any partial word.
REQ-019 SHALL shift accepted bytes into a 32-bit assembly register MSB-first; the 4th accepted byte completes a word.
REQ-020 SHALL assert mem_we for exactly one cycle, the cycle after the 4th byte transfer, with mem_addr = current word address and mem_wdata = assembled word; the address and word_count then increment by 1.
REQ-021 SHALL keep in_ready high during the write cycle so that back-to-back bytes sustain one byte per cycle.
REQ-022 SHALL, when the completed word equals HALT_WORD, still write it, then go LOAD -> START; in_ready is 0 from the write cycle onward.
REQ-023 SHALL, in START, pulse core_start for one cycle, set core_run = 1, and go to RUN.
REQ-024 SHALL, in RUN, hold core_run = 1 and in_ready = 0 until load_start or rst.
REQ-025 SHALL, when a non-HALT word is written at address 2^ADDR_W-1, go to ERROR with err_overflow = 1, core_run = 0, in_ready = 0; the address does not wrap.
REQ-026 SHALL ignore in_valid outside LOAD; mem_we is never asserted outside the write cycle of REQ-020.
REQ-027 SHALL give load_start priority over a simultaneous byte transfer; that byte is dropped.

Reset
REQ-028 SHALL, on rst, enter IDLE, clear the byte index, the word address and the assembly register, and drive all outputs to 0 (in_ready, mem_we, mem_addr, mem_wdata, core_start, core_run, word_count, err_overflow).
REQ-029 SHALL give rst priority over load_start; rst mid-load suppresses any pending mem_we.

Structure
REQ-030 SHALL place the state enumeration and the default HALT_WORD constant in shared package mips_loader_pkg.
REQ-031 SHALL implement byte-to-word assembly in sub-module mips_word_assembler (byte index counter, shift register, word-done flag).

Verification
REQ-032 SHALL test: rst; load_start; bytes 48 20 08 F5 48 40 0F FF FF FF FF FF, valid every cycle -> writes Mem[0]=482008F5, Mem[1]=48400FFF, Mem[2]=FFFFFFFF; one core_start pulse; core_run=1; word_count=3.
REQ-033 SHALL test: the same stream with in_valid toggled every other cycle -> identical writes; no byte lost or duplicated.
REQ-034 SHALL test: ADDR_W=2 with 4 non-HALT words -> 4 writes at addresses 0..3; err_overflow=1; core_run=0; no 5th write.
REQ-035 SHALL test: load_start after 6 bytes of a load -> partial word discarded; the next 4 bytes are written to address 0 with word_count=1.
REQ-036 SHALL test: rst asserted on the cycle of a 4th byte transfer -> no mem_we; all outputs 0 next cycle.
REQ-037 SHALL test: load_start while in RUN -> core_run=0 next cycle; in_ready=1; the new load overwrites from address 0.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared state encoding and constants for the program loader
`timescale 1ns/1ps
package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_word_assembler.sv
// rtl/mips_word_assembler.sv - packs an MSB-first byte stream into 32-bit words
`timescale 1ns/1ps
module mips_word_assembler (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_xfer,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_idx;

    // word_done is high for the single cycle after the fourth byte lands
    always_ff @(posedge clk1) begin
        if (rst || clear) begin
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (byte_xfer) begin
                word      <= {word[23:0], byte_data};
                byte_idx  <= byte_idx + 2'd1;
                word_done <= (byte_idx == 2'd3);
            end
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - byte-stream program loader for the MIPS instruction memory
`timescale 1ns/1ps
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_start,
    output logic              core_run,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [31:0]       asm_word;
    logic              asm_done;
    logic              byte_xfer;
    logic              write_cycle;
    logic              word_is_halt;
    logic              at_last;

    // a restart request wins over a byte offered in the same cycle
    assign byte_xfer    = in_valid && in_ready && !load_start;
    assign write_cycle  = (state == ST_LOAD) && asm_done;
    assign word_is_halt = (asm_word == HALT_WORD);
    assign at_last      = (addr == LAST_ADDR);

    mips_word_assembler u_asm (
        .clk1      (clk1),
        .rst       (rst),
        .clear     (load_start),
        .byte_xfer (byte_xfer),
        .byte_data (in_data),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        core_start   = 1'b0;
        core_run     = 1'b0;
        err_overflow = 1'b0;
        case (state)
            ST_LOAD: begin
                // stop accepting as soon as the final word of the load is being written
                in_ready = !(asm_done && (word_is_halt || at_last));
                mem_we   = asm_done;
                if (asm_done) begin
                    if (word_is_halt) begin
                        state_n = ST_START;
                    end else if (at_last) begin
                        state_n = ST_ERROR;
                    end
                end
            end
            ST_START: begin
                core_start = 1'b1;
                core_run   = 1'b1;
                state_n    = ST_RUN;
            end
            ST_RUN: begin
                core_run = 1'b1;
            end
            ST_ERROR: begin
                err_overflow = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (load_start) begin
            state_n = ST_LOAD;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst || load_start) begin
            addr  <= '0;
            count <= '0;
        end else if (write_cycle) begin
            count <= count + (ADDR_W+1)'(1);
            if (!at_last) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign mem_addr   = addr;
    assign mem_wdata  = asm_word;
    assign word_count = count;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - randomized self-checking bench for mips_prog_loader
`timescale 1ns/1ps
module tb_mips_prog_loader;

    typedef logic [7:0] byte_q_t[$];
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    logic        a_load_start = 1'b0, a_in_valid = 1'b0;
    logic [7:0]  a_in_data = 8'd0;
    logic        a_in_ready, a_mem_we, a_core_start, a_core_run, a_err_overflow;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [10:0] a_word_count;

    logic        b_load_start = 1'b0, b_in_valid = 1'b0;
    logic [7:0]  b_in_data = 8'd0;
    logic        b_in_ready, b_mem_we, b_core_start, b_core_run, b_err_overflow;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_word_count;

    mips_prog_loader #(.ADDR_W(10)) dut_a (
        .clk1(clk1), .rst(rst), .load_start(a_load_start), .in_valid(a_in_valid),
        .in_data(a_in_data), .in_ready(a_in_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .core_start(a_core_start),
        .core_run(a_core_run), .word_count(a_word_count), .err_overflow(a_err_overflow)
    );

    mips_prog_loader #(.ADDR_W(2)) dut_b (
        .clk1(clk1), .rst(rst), .load_start(b_load_start), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_ready(b_in_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .core_start(b_core_start),
        .core_run(b_core_run), .word_count(b_word_count), .err_overflow(b_err_overflow)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // write monitors: every observed write and core_start pulse, per instance
    int          a_wa[$], b_wa[$];
    logic [31:0] a_wd[$], b_wd[$];
    int          a_starts = 0, b_starts = 0;
    int          a_wbase = 0, b_wbase = 0, a_sbase = 0, b_sbase = 0;

    always @(negedge clk1) begin
        if (a_mem_we) begin a_wa.push_back(int'(a_mem_addr)); a_wd.push_back(a_mem_wdata); end
        if (b_mem_we) begin b_wa.push_back(int'(b_mem_addr)); b_wd.push_back(b_mem_wdata); end
        if (a_core_start) a_starts++;
        if (b_core_start) b_starts++;
    end

    // reference: group bytes into words, stop at the halt word or when memory is full
    int          e_wa[$];
    logic [31:0] e_wd[$];
    bit          e_halt, e_ovf;

    function automatic void model(input byte_q_t b, input int depth);
        logic [31:0] w;
        e_wa.delete(); e_wd.delete();
        e_halt = 0; e_ovf = 0;
        for (int i = 0; i < b.size() / 4; i++) begin
            w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            e_wa.push_back(i); e_wd.push_back(w);
            if (w == HALT) begin e_halt = 1; break; end
            if (i == depth - 1) begin e_ovf = 1; break; end
        end
    endfunction

    byte_q_t stim;

    function automatic void add_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) stim.push_back(w[8*i +: 8]);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT) w = 32'd0;
        return w;
    endfunction

    task automatic send(input bit sel, input byte_q_t bytes, input int mode);
        int  idx = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  v, xfer;
        while (idx < bytes.size() && cyc < 2000) begin
            @(negedge clk1);
            v   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
            tog = !tog;
            if (sel) begin b_in_valid = v; b_in_data = bytes[idx]; xfer = v && b_in_ready; end
            else     begin a_in_valid = v; a_in_data = bytes[idx]; xfer = v && a_in_ready; end
            @(posedge clk1);
            if (xfer) idx++;
            cyc++;
        end
        @(negedge clk1);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        check("bytes_sent", idx, bytes.size());
    endtask

    task automatic restart(input bit sel);
        @(negedge clk1);
        if (sel) b_load_start = 1'b1; else a_load_start = 1'b1;
        @(negedge clk1);
        a_load_start = 1'b0;
        b_load_start = 1'b0;
        a_wbase = a_wa.size(); b_wbase = b_wa.size();
        a_sbase = a_starts;    b_sbase = b_starts;
        check("restart_core_run", sel ? b_core_run : a_core_run, 0);
        check("restart_in_ready", sel ? b_in_ready : a_in_ready, 1);
        check("restart_word_count", sel ? 64'(b_word_count) : 64'(a_word_count), 0);
        check("restart_err", sel ? b_err_overflow : a_err_overflow, 0);
    endtask

    task automatic verify(input bit sel);
        int          wa[$];
        logic [31:0] wd[$];
        int          n;
        repeat (4) @(negedge clk1);
        if (sel) begin
            for (int i = b_wbase; i < b_wa.size(); i++) begin wa.push_back(b_wa[i]); wd.push_back(b_wd[i]); end
        end else begin
            for (int i = a_wbase; i < a_wa.size(); i++) begin wa.push_back(a_wa[i]); wd.push_back(a_wd[i]); end
        end
        check("n_writes", wa.size(), e_wa.size());
        n = (wa.size() < e_wa.size()) ? wa.size() : e_wa.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("waddr[%0d]", i), wa[i], e_wa[i]);
            check($sformatf("wdata[%0d]", i), wd[i], e_wd[i]);
        end
        check("core_start_pulses", sel ? (b_starts - b_sbase) : (a_starts - a_sbase), e_halt ? 1 : 0);
        check("core_run", sel ? b_core_run : a_core_run, e_halt);
        check("err_overflow", sel ? b_err_overflow : a_err_overflow, e_ovf);
        check("word_count", sel ? 64'(b_word_count) : 64'(a_word_count), e_wa.size());
        check("in_ready_after", sel ? b_in_ready : a_in_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte_q_t d, h;
        int      n;

        repeat (2) @(negedge clk1);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_core_start", a_core_start, 0);
        check("rst_core_run", a_core_run, 0);
        check("rst_word_count", a_word_count, 0);
        check("rst_err", a_err_overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk1);
        check("idle_in_ready", a_in_ready, 0);

        d = '{8'h48, 8'h20, 8'h08, 8'hF5, 8'h48, 8'h40, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model(d, 1024);
        restart(0); send(0, d, 0); verify(0);
        restart(0); send(0, d, 1); verify(0);

        for (int k = 0; k < 5; k++) begin
            stim.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) add_word(rand_word());
            add_word(HALT);
            model(stim, 1024);
            restart(0); send(0, stim, $urandom_range(0, 2)); verify(0);
        end

        // abandon a load after six bytes; the restart must discard it
        stim.delete();
        for (int j = 0; j < 6; j++) stim.push_back(8'($urandom));
        restart(0); send(0, stim, 0);
        restart(0);
        stim.delete();
        add_word(rand_word());
        send(0, stim, 2);
        repeat (2) @(negedge clk1);
        check("partial_word_count", a_word_count, 1);
        check("partial_n_writes", a_wa.size() - a_wbase, 1);
        check("partial_in_ready", a_in_ready, 1);
        h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send(0, h, 0);
        add_word(HALT);
        model(stim, 1024);
        verify(0);

        // reset lands on the cycle the fourth byte of the second word transfers
        stim.delete();
        add_word(rand_word());
        for (int j = 0; j < 3; j++) stim.push_back(8'($urandom));
        restart(0); send(0, stim, 0);
        @(negedge clk1);
        a_in_valid = 1'b1; a_in_data = 8'h5A; rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0; a_in_valid = 1'b0;
        check("rst4_mem_we", a_mem_we, 0);
        check("rst4_in_ready", a_in_ready, 0);
        check("rst4_mem_addr", a_mem_addr, 0);
        check("rst4_mem_wdata", a_mem_wdata, 0);
        check("rst4_core_start", a_core_start, 0);
        check("rst4_core_run", a_core_run, 0);
        check("rst4_word_count", a_word_count, 0);
        check("rst4_err", a_err_overflow, 0);
        repeat (3) @(negedge clk1);
        check("rst4_n_writes", a_wa.size() - a_wbase, 1);

        // small memory: four ordinary words must overflow without a fifth write
        stim.delete();
        for (int j = 0; j < 4; j++) add_word(rand_word());
        model(stim, 4);
        restart(1); send(1, stim, 2);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk1);
            b_in_valid = 1'b1; b_in_data = 8'($urandom);
        end
        @(negedge clk1);
        b_in_valid = 1'b0;
        verify(1);
        check("ovf_mem_addr_held", b_mem_addr, 3);

        // small memory: halt in the last slot releases the core instead
        stim.delete();
        for (int j = 0; j < 3; j++) add_word(rand_word());
        add_word(HALT);
        model(stim, 4);
        restart(1); send(1, stim, 1); verify(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
